// File: rtl/change_disp_pkg.sv
// Shared types and constants for the change dispenser.
// State encodings are plain constants so older blocks can compare against them directly.
package change_disp_pkg;

    localparam int unsigned COIN_VALUE_RS = 10;
    localparam int unsigned CHANGE_W      = 3;

    typedef logic [2:0] disp_state_t;

    localparam disp_state_t IDLE     = 3'd0;
    localparam disp_state_t GATE     = 3'd1;
    localparam disp_state_t DISPENSE = 3'd2;
    localparam disp_state_t DONE     = 3'd3;
    localparam disp_state_t FAULT    = 3'd4;

endpackage

// File: rtl/sense_sync.sv
// Two-flop synchroniser for an asynchronous opto input, followed by a rising-edge detector.
// rise is a one-cycle pulse two clocks after the pin goes high.
module sense_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/change_dispenser.sv
// Vend-downstream stage: opens the product gate, then runs the coin hopper until the owed change
// is counted, with a per-coin timeout. Optional coin ledger enabled by `CHANGE_LEDGER_EN.
module change_dispenser
    import change_disp_pkg::*;
#(
    parameter int unsigned GATE_CYCLES  = 4,
    parameter int unsigned COIN_TIMEOUT = 1000,
    parameter int unsigned LEDGER_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                vend,
    input  logic [CHANGE_W-1:0] change,
    input  logic                hopper_sense,
    input  logic                fault_clr,
    output logic                product_gate,
    output logic                motor_en,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [CHANGE_W-1:0] coins_left,
    output logic                overrun,
    output logic [LEDGER_W-1:0] coins_paid
);

    localparam int unsigned GCW = $clog2(GATE_CYCLES + 1);
    localparam int unsigned TW  = $clog2(COIN_TIMEOUT + 1);

    localparam logic [GCW-1:0] GATE_LOAD  = GCW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0]  TIMER_LAST = TW'(COIN_TIMEOUT - 1);
    localparam logic [TW-1:0]  TIMER_SAT  = TW'(COIN_TIMEOUT);

    disp_state_t         state_q, state_d;
    logic [GCW-1:0]      gate_cnt_q, gate_cnt_d;
    logic [CHANGE_W-1:0] coins_left_q, coins_left_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                overrun_q, overrun_d;
    logic                vend_q;
    logic                vend_rise;
    logic                coin_evt;

    sense_sync u_hopper_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (hopper_sense),
        .rise     (coin_evt)
    );

    assign vend_rise = vend & ~vend_q;

    always_comb begin
        state_d      = state_q;
        gate_cnt_d   = gate_cnt_q;
        coins_left_d = coins_left_q;
        timer_d      = timer_q;
        overrun_d    = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (vend_rise) begin
                    state_d      = GATE;
                    coins_left_d = change;
                    gate_cnt_d   = GATE_LOAD;
                end
            end
            GATE: begin
                if (gate_cnt_q == '0) begin
                    timer_d = '0;
                    state_d = (coins_left_q == '0) ? DONE : DISPENSE;
                end else begin
                    gate_cnt_d = gate_cnt_q - 1'b1;
                end
            end
            DISPENSE: begin
                // A coin seen on the timeout cycle still counts.
                if (coin_evt) begin
                    timer_d = '0;
                    if (coins_left_q != '0) begin
                        coins_left_d = coins_left_q - 1'b1;
                    end
                    if (coins_left_q <= CHANGE_W'(1)) begin
                        state_d = DONE;
                    end
                end else if (timer_q >= TIMER_LAST) begin
                    state_d = FAULT;
                end else if (timer_q != TIMER_SAT) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (fault_clr) begin
                    state_d      = IDLE;
                    coins_left_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fault_clr) begin
            overrun_d = 1'b0;
        end else if (vend_rise && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            gate_cnt_q   <= '0;
            coins_left_q <= '0;
            timer_q      <= '0;
            overrun_q    <= 1'b0;
            vend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_cnt_q   <= gate_cnt_d;
            coins_left_q <= coins_left_d;
            timer_q      <= timer_d;
            overrun_q    <= overrun_d;
            vend_q       <= vend;
        end
    end

    // Outputs decode straight from state so reset drops the motor without waiting for a clock.
    assign product_gate = (state_q == GATE);
    assign motor_en     = (state_q == DISPENSE);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign fault        = (state_q == FAULT);
    assign coins_left   = coins_left_q;
    assign overrun      = overrun_q;

`ifdef CHANGE_LEDGER_EN
    logic                coin_accept;
    logic [LEDGER_W-1:0] ledger_q;

    assign coin_accept = (state_q == DISPENSE) && coin_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ledger_q <= '0;
        end else if (coin_accept) begin
            ledger_q <= ledger_q + 1'b1;
        end
    end

    assign coins_paid = ledger_q;
`else
    assign coins_paid = '0;
`endif

endmodule
